// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers channel-tagged 16-bit samples in a small FIFO and
// serialises each one into a 5-byte frame (SYNC, CHAN, MSB, LSB, CSUM) handed
// to the UART TX controller one byte at a time over a valid/ready handshake.
module uart_tx_packetizer #(
   parameter int         FIFO_DEPTH = 8,
   parameter int         ADDR_W     = 3,
   parameter int         CH_W       = 2,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [15:0]       sample_in,
   input  logic [CH_W-1:0]   sample_ch,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic [7:0]        tx_byte,
   output logic              tx_byte_valid,
   input  logic              tx_byte_ready,
   output logic [ADDR_W:0]   fifo_level,
   output logic [7:0]        overflow_cnt,
   output logic              busy
);

   localparam int              ENTRY_W = CH_W + 16;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_CHAN,
      ST_MSB,
      ST_LSB,
      ST_CSUM
   } state_t;

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]  wr_ptr_reg;
   logic [ADDR_W-1:0]  rd_ptr_reg;
   logic [ADDR_W:0]    level_reg;
   logic [7:0]         overflow_reg;

   state_t             state_reg;
   state_t             state_next;
   logic [CH_W-1:0]    ch_reg;
   logic [15:0]        data_reg;
   logic [7:0]         tx_byte_reg;
   logic [7:0]         tx_byte_next;
   logic               tx_valid_reg;

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               drop;
   logic [7:0]         chan_byte;
   logic [7:0]         csum_byte;

   // FIFO status comes only from registered level, so tx_byte_ready never
   // reaches sample_ready combinationally.
   assign full      = (level_reg == DEPTH_L);
   assign empty     = (level_reg == '0);
   assign push      = sample_valid && !full;
   assign drop      = sample_valid && full;
   assign pop       = (state_reg == ST_IDLE) && !empty;
   assign chan_byte = 8'(ch_reg);
   assign csum_byte = chan_byte ^ data_reg[15:8] ^ data_reg[7:0];

   // Sample storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {sample_ch, sample_in};
      end
   end

   // FIFO pointers, occupancy and saturating drop counter.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
         if (drop && (overflow_reg != 8'hFF)) begin
            overflow_reg <= overflow_reg + 1'b1;
         end
      end
   end

   // Frame state, frame registers and the registered byte offered downstream.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_reg    <= ST_IDLE;
         ch_reg       <= '0;
         data_reg     <= '0;
         tx_byte_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tx_byte_reg  <= tx_byte_next;
         tx_valid_reg <= (state_next != ST_IDLE);
         if (pop) begin
            {ch_reg, data_reg} <= mem[rd_ptr_reg];
         end
      end
   end

   // Next state walks the frame one byte per accepted handshake; the byte for
   // the upcoming state is precomputed so tx_byte is a plain register.
   always_comb begin
      state_next   = state_reg;
      tx_byte_next = tx_byte_reg;
      case (state_reg)
         ST_IDLE: if (!empty)       state_next = ST_SYNC;
         ST_SYNC: if (tx_byte_ready) state_next = ST_CHAN;
         ST_CHAN: if (tx_byte_ready) state_next = ST_MSB;
         ST_MSB:  if (tx_byte_ready) state_next = ST_LSB;
         ST_LSB:  if (tx_byte_ready) state_next = ST_CSUM;
         ST_CSUM: if (tx_byte_ready) state_next = ST_IDLE;
         default:                    state_next = ST_IDLE;
      endcase
      case (state_next)
         ST_SYNC: tx_byte_next = SYNC_BYTE;
         ST_CHAN: tx_byte_next = chan_byte;
         ST_MSB:  tx_byte_next = data_reg[15:8];
         ST_LSB:  tx_byte_next = data_reg[7:0];
         ST_CSUM: tx_byte_next = csum_byte;
         default: tx_byte_next = tx_byte_reg;
      endcase
   end

   assign sample_ready  = !full;
   assign tx_byte       = tx_byte_reg;
   assign tx_byte_valid = tx_valid_reg;
   assign fifo_level    = level_reg;
   assign overflow_cnt  = overflow_reg;
   assign busy          = (state_reg != ST_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed bench for uart_tx_packetizer: table of samples with hand-computed
// frames, plus sequences for backpressure, fill/overflow, back-to-back frames
// and mid-frame reset.
module tb_uart_tx_packetizer;

   logic        clk = 1'b0;
   logic        reset_b;
   logic [15:0] sample_in;
   logic [1:0]  sample_ch;
   logic        sample_valid;
   logic        sample_ready;
   logic [7:0]  tx_byte;
   logic        tx_byte_valid;
   logic        tx_byte_ready;
   logic [3:0]  fifo_level;
   logic [7:0]  overflow_cnt;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [15:0]      data;
      logic [1:0]       ch;
      logic [0:4][7:0]  exp_bytes;
   } vec_t;

   vec_t vecs [5];

   uart_tx_packetizer dut (
      .clk           (clk),
      .reset_b       (reset_b),
      .sample_in     (sample_in),
      .sample_ch     (sample_ch),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .tx_byte       (tx_byte),
      .tx_byte_valid (tx_byte_valid),
      .tx_byte_ready (tx_byte_ready),
      .fifo_level    (fifo_level),
      .overflow_cnt  (overflow_cnt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [15:0] d, input logic [1:0] c);
      sample_in    = d;
      sample_ch    = c;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic do_reset;
      reset_b = 1'b0;
      repeat (2) tick();
      reset_b = 1'b1;
      tick();
   endtask

   initial begin
      vecs[0] = '{16'h1234, 2'd2, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24}};
      vecs[1] = '{16'hFFFF, 2'd3, {8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h03}};
      vecs[2] = '{16'h0000, 2'd0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{16'hA55A, 2'd1, {8'hA5, 8'h01, 8'hA5, 8'h5A, 8'hFE}};
      vecs[4] = '{16'h8001, 2'd2, {8'hA5, 8'h02, 8'h80, 8'h01, 8'h83}};

      reset_b       = 1'b0;
      sample_in     = '0;
      sample_ch     = '0;
      sample_valid  = 1'b0;
      tx_byte_ready = 1'b0;
      #1;
      // Reset values
      check("rst_sample_ready", sample_ready, 1);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_tx_valid", tx_byte_valid, 0);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow_cnt, 0);
      check("rst_busy", busy, 0);
      repeat (2) tick();
      reset_b = 1'b1;
      tick();

      // Table: one isolated sample per record, ready held high
      tx_byte_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_one(vecs[i].data, vecs[i].ch);
         check($sformatf("v%0d_accept_valid", i), tx_byte_valid, 0);
         check($sformatf("v%0d_accept_level", i), fifo_level, 1);
         tick();
         for (int b = 0; b < 5; b++) begin
            check($sformatf("v%0d_byte%0d", i, b), {tx_byte_valid, tx_byte},
                  {1'b1, vecs[i].exp_bytes[b]});
            tick();
         end
         check($sformatf("v%0d_end_valid", i), tx_byte_valid, 0);
         check($sformatf("v%0d_end_busy", i), busy, 0);
         $display("[TB] frame data=%h ch=%0d done", vecs[i].data, vecs[i].ch);
      end

      // Backpressure during MSB
      push_one(16'h1234, 2'd2);
      tick();
      tick();
      tick();
      check("bp_msb_shown", {tx_byte_valid, tx_byte}, {1'b1, 8'h12});
      tx_byte_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("bp_hold%0d", c), {tx_byte_valid, tx_byte}, {1'b1, 8'h12});
      end
      tx_byte_ready = 1'b1;
      tick();
      check("bp_lsb", {tx_byte_valid, tx_byte}, {1'b1, 8'h34});
      tick();
      check("bp_csum", {tx_byte_valid, tx_byte}, {1'b1, 8'h24});
      tick();
      check("bp_done", tx_byte_valid, 0);
      $display("[TB] backpressure frame done");

      // Fill with ready low: first sample is popped into the frame registers
      tx_byte_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample_in    = 16'h1000 + 16'(i);
         sample_ch    = 2'(i);
         sample_valid = 1'b1;
         tick();
         if (i == 7) check("fill_level7", fifo_level, 7);
         if (i == 8) begin
            check("fill_level8", fifo_level, 8);
            check("fill_not_ready", sample_ready, 0);
            check("fill_no_drop_yet", overflow_cnt, 0);
         end
         if (i == 9) begin
            check("fill_drop_one", overflow_cnt, 1);
            check("fill_level_held", fifo_level, 8);
         end
      end
      $display("[TB] fill done level=%0d", fifo_level);

      // Overflow saturation: 300 more pushes while full
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 252) check("ovf_254", overflow_cnt, 254);
      end
      sample_valid = 1'b0;
      check("ovf_sat", overflow_cnt, 255);
      check("ovf_level", fifo_level, 8);
      check("ovf_frame_held", {tx_byte_valid, tx_byte}, {1'b1, 8'hA5});
      tick();
      check("ovf_sat_hold", overflow_cnt, 255);
      $display("[TB] overflow saturation done");

      do_reset();
      check("post_rst_overflow", overflow_cnt, 0);

      // Back-to-back: 4 queued samples, then ready high
      tx_byte_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample_in    = vecs[i].data;
         sample_ch    = vecs[i].ch;
         sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      check("b2b_level", fifo_level, 3);
      tx_byte_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < 5; b++) begin
            check($sformatf("b2b_f%0d_byte%0d", f, b), {tx_byte_valid, tx_byte},
                  {1'b1, vecs[f].exp_bytes[b]});
            tick();
         end
         check($sformatf("b2b_f%0d_gap", f), tx_byte_valid, 0);
         check($sformatf("b2b_f%0d_busy", f), busy, (f < 3) ? 1 : 0);
         $display("[TB] back-to-back frame %0d done", f);
         if (f < 3) tick();
      end

      // Reset during CHAN byte
      push_one(vecs[0].data, vecs[0].ch);
      push_one(vecs[1].data, vecs[1].ch);
      tick();
      check("mid_chan_shown", {tx_byte_valid, tx_byte}, {1'b1, 8'h02});
      tx_byte_ready = 1'b0;
      #2;
      reset_b = 1'b0;
      #1;
      check("mid_rst_valid", tx_byte_valid, 0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", sample_ready, 1);
      tick();
      reset_b = 1'b1;
      tick();
      tx_byte_ready = 1'b1;
      push_one(vecs[4].data, vecs[4].ch);
      check("fresh_accept_valid", tx_byte_valid, 0);
      tick();
      for (int b = 0; b < 5; b++) begin
         check($sformatf("fresh_byte%0d", b), {tx_byte_valid, tx_byte},
               {1'b1, vecs[4].exp_bytes[b]});
         tick();
      end
      check("fresh_end_busy", busy, 0);
      $display("[TB] post-reset frame done");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
